// File: rtl/exponential_averager_filter.sv
`timescale 1ns/1ps
// Self-stimulating demo: 64-point sine generator with optional LFSR noise feeding a
// first-order exponential averager (alpha = 2^-ALPHA_SHIFT).
module exponential_averager_filter #(
   parameter int DATA_W      = 16,
   parameter int ALPHA_SHIFT = 4,
   parameter int DIV         = 4,
   parameter int NOISE_EN    = 1,
   parameter int NOISE_BITS  = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [DATA_W-1:0] q_sine,
   output logic [DATA_W-1:0] q
);

   localparam int ACC_W = DATA_W + ALPHA_SHIFT;
   localparam int SUM_W = DATA_W + 1;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [15:0]      LFSR_SEED = 16'hACE1;

   // First quadrant of round(8192*sin(2*pi*k/64)), k = 0..16; the rest is folded.
   function automatic logic signed [15:0] quarter_sine(input logic [4:0] idx);
      logic signed [15:0] v;
      case (idx)
         5'd0:    v = 16'sd0;
         5'd1:    v = 16'sd803;
         5'd2:    v = 16'sd1598;
         5'd3:    v = 16'sd2378;
         5'd4:    v = 16'sd3135;
         5'd5:    v = 16'sd3862;
         5'd6:    v = 16'sd4551;
         5'd7:    v = 16'sd5197;
         5'd8:    v = 16'sd5793;
         5'd9:    v = 16'sd6333;
         5'd10:   v = 16'sd6811;
         5'd11:   v = 16'sd7225;
         5'd12:   v = 16'sd7568;
         5'd13:   v = 16'sd7839;
         5'd14:   v = 16'sd8035;
         5'd15:   v = 16'sd8153;
         5'd16:   v = 16'sd8192;
         default: v = 16'sd0;
      endcase
      return v;
   endfunction

   function automatic logic signed [15:0] sine_lut(input logic [5:0] ph);
      logic [4:0]         fold;
      logic signed [15:0] mag;
      fold = ph[4] ? (5'd16 - {1'b0, ph[3:0]}) : {1'b0, ph[3:0]};
      mag  = quarter_sine(fold);
      return ph[5] ? -mag : mag;
   endfunction

   logic [CNT_W-1:0]         div_cnt_q, div_cnt_d;
   logic [5:0]               phase_q, phase_d;
   logic [15:0]              lfsr_q, lfsr_d;
   logic signed [DATA_W-1:0] q_sine_q, q_sine_d;
   logic                     strobe_d_q;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0]        q_q, q_d;

   logic                     strobe;
   logic signed [DATA_W-1:0] noise;
   logic signed [SUM_W-1:0]  sum;
   logic signed [DATA_W-1:0] sat_val;

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path can infer a latch.
      div_cnt_d = div_cnt_q;
      phase_d   = phase_q;
      lfsr_d    = lfsr_q;
      q_sine_d  = q_sine_q;
      acc_d     = acc_q;
      q_d       = q_q;
      noise     = '0;

      strobe = (div_cnt_q == CNT_LAST);
      if (NOISE_EN != 0) begin
         noise = {{(DATA_W-NOISE_BITS){lfsr_q[NOISE_BITS-1]}}, lfsr_q[NOISE_BITS-1:0]};
      end

      // One guard bit detects overflow; clamp toward the sign of the true sum.
      sum     = SUM_W'(sine_lut(phase_q)) + SUM_W'(noise);
      sat_val = (sum[SUM_W-1] != sum[SUM_W-2]) ?
                {sum[SUM_W-1], {(DATA_W-1){~sum[SUM_W-1]}}} : sum[DATA_W-1:0];

      if (strobe) begin
         div_cnt_d = '0;
         phase_d   = phase_q + 6'd1;
         lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         q_sine_d  = sat_val;
      end else begin
         div_cnt_d = div_cnt_q + CNT_W'(1);
      end

      // acc holds y*2^K; the upper DATA_W bits are y rounded toward -inf.
      if (strobe_d_q) begin
         acc_d = acc_q - (acc_q >>> ALPHA_SHIFT) + ACC_W'(q_sine_q);
         q_d   = acc_d[ACC_W-1 -: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q  <= '0;
         phase_q    <= '0;
         lfsr_q     <= LFSR_SEED;
         q_sine_q   <= '0;
         strobe_d_q <= 1'b0;
         acc_q      <= '0;
         q_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         div_cnt_q  <= div_cnt_d;
         phase_q    <= phase_d;
         lfsr_q     <= lfsr_d;
         q_sine_q   <= q_sine_d;
         strobe_d_q <= strobe;
         acc_q      <= acc_d;
         q_q        <= q_d;
      end
   end

   assign q_sine = q_sine_q;
   assign q      = q_q;

endmodule

// File: tb/tb_exponential_averager_filter.sv
`timescale 1ns/1ps
// Bench for exponential_averager_filter: four configurations run side by side against
// a sample-level model built from real-valued sine, the LFSR rule and exact filter arithmetic.
module tb_exponential_averager_filter;

   localparam int    NCFG = 4;
   localparam int    NS   = 800;
   localparam int    P1   = 700;
   localparam real   PI   = 3.141592653589793;

   typedef struct {
      string name;
      int    cfg;
      int    idx;
      int    kind;
      int    expv;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] qs_w [NCFG];
   logic [15:0] q_w  [NCFG];

   int divs  [NCFG] = '{4, 4, 4, 1};
   int ks    [NCFG] = '{4, 0, 4, 8};
   int noise [NCFG] = '{0, 0, 1, 1};

   int mx [NCFG][NS];
   int my [NCFG][NS];
   int hist_qs [NCFG][P1+1];
   int hist_q  [NCFG][P1+1];

   int pass_cnt  = 0;
   int total_cnt = 0;
   int xcnt      = 0;

   exponential_averager_filter #(.DATA_W(16), .ALPHA_SHIFT(4), .DIV(4), .NOISE_EN(0), .NOISE_BITS(10))
      u_clean (.clk(clk), .reset_n(reset_n), .q_sine(qs_w[0]), .q(q_w[0]));
   exponential_averager_filter #(.DATA_W(16), .ALPHA_SHIFT(0), .DIV(4), .NOISE_EN(0), .NOISE_BITS(10))
      u_k0 (.clk(clk), .reset_n(reset_n), .q_sine(qs_w[1]), .q(q_w[1]));
   exponential_averager_filter #(.DATA_W(16), .ALPHA_SHIFT(4), .DIV(4), .NOISE_EN(1), .NOISE_BITS(10))
      u_noise (.clk(clk), .reset_n(reset_n), .q_sine(qs_w[2]), .q(q_w[2]));
   exponential_averager_filter #(.DATA_W(16), .ALPHA_SHIFT(8), .DIV(1), .NOISE_EN(1), .NOISE_BITS(10))
      u_stress (.clk(clk), .reset_n(reset_n), .q_sine(qs_w[3]), .q(q_w[3]));

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint expv);
      total_cnt++;
      if (act == expv) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   function automatic int ref_lut(input int k);
      real v;
      v = 8192.0 * $sin(2.0 * PI * real'(k) / 64.0);
      if (v >= 0.0) return $rtoi($floor(v + 0.5));
      return -$rtoi($floor(-v + 0.5));
   endfunction

   function automatic int lfsr_step(input int s);
      int b;
      b = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
      return ((s << 1) & 16'hFFFF) | b;
   endfunction

   function automatic int noise_of(input int s, input int nb);
      int v;
      v = s & ((1 << nb) - 1);
      if (v >= (1 << (nb - 1))) v -= (1 << nb);
      return v;
   endfunction

   function automatic longint floor_div(input longint a, input longint d);
      longint qt;
      qt = a / d;
      if ((a % d != 0) && (a < 0)) qt -= 1;
      return qt;
   endfunction

   task automatic build_model();
      for (int c = 0; c < NCFG; c++) begin
         int     s;
         longint acc;
         s   = 16'hACE1;
         acc = 0;
         for (int n = 0; n < NS; n++) begin
            int x;
            x = ref_lut(n % 64) + ((noise[c] != 0) ? noise_of(s, 10) : 0);
            if (x > 32767)  x = 32767;
            if (x < -32768) x = -32768;
            s   = lfsr_step(s);
            acc = acc - floor_div(acc, longint'(1) << ks[c]) + x;
            mx[c][n] = x;
            my[c][n] = int'(floor_div(acc, longint'(1) << ks[c]));
         end
      end
   endtask

   // Edge e counts rising edges after reset release, starting at 1.
   function automatic int exp_qs(input int c, input int e);
      int n;
      n = e / divs[c] - 1;
      return (n < 0) ? 0 : mx[c][n];
   endfunction

   function automatic int exp_q(input int c, input int e);
      int n;
      n = (e - 1) / divs[c] - 1;
      return (n < 0) ? 0 : my[c][n];
   endfunction

   task automatic run_edges(input int n_edges, input bit rec, input string tag);
      for (int e = 1; e <= n_edges; e++) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < NCFG; c++) begin
            if ($isunknown(qs_w[c]) || $isunknown(q_w[c])) xcnt++;
            check($sformatf("%s_c%0d_qsine_e%0d", tag, c, e), $signed(qs_w[c]), exp_qs(c, e));
            check($sformatf("%s_c%0d_q_e%0d", tag, c, e), $signed(q_w[c]), exp_q(c, e));
            if (rec) begin
               hist_qs[c][e] = int'($signed(qs_w[c]));
               hist_q[c][e]  = int'($signed(q_w[c]));
            end
         end
      end
   endtask

   task automatic async_reset(input string tag);
      #($urandom_range(1, 3));
      reset_n = 1'b0;
      #1;
      for (int c = 0; c < NCFG; c++) begin
         check($sformatf("%s_async_c%0d_qsine", tag, c), $signed(qs_w[c]), 0);
         check($sformatf("%s_async_c%0d_q", tag, c), $signed(q_w[c]), 0);
      end
      @(posedge clk);
      #1;
      check($sformatf("%s_held_qsine", tag), $signed(qs_w[3]), 0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      vec_t vecs [12];
      int   mism, dev, mx_v, arg_n, pmin_x, pmax_x, pmin_y, pmax_y, peak;

      build_model();
      vecs[0]  = '{"sine_s0",     0, 0,  0, 0};
      vecs[1]  = '{"sine_s1",     0, 1,  0, 803};
      vecs[2]  = '{"sine_s2",     0, 2,  0, 1598};
      vecs[3]  = '{"sine_s8",     0, 8,  0, 5793};
      vecs[4]  = '{"sine_s16",    0, 16, 0, 8192};
      vecs[5]  = '{"sine_s32",    0, 32, 0, 0};
      vecs[6]  = '{"sine_s48",    0, 48, 0, -8192};
      vecs[7]  = '{"avg_s0",      0, 0,  1, 0};
      vecs[8]  = '{"avg_s1",      0, 1,  1, 50};
      vecs[9]  = '{"avg_s2",      0, 2,  1, 146};
      vecs[10] = '{"noise_first", 2, 0,  0, 225};
      vecs[11] = '{"k0_s16",      1, 16, 1, 8192};

      // Power-on reset held 20 ns with the clock running; release lands on a falling edge.
      #19;
      for (int c = 0; c < NCFG; c++) begin
         check($sformatf("por_c%0d_qsine", c), $signed(qs_w[c]), 0);
         check($sformatf("por_c%0d_q", c), $signed(q_w[c]), 0);
      end
      #1;
      reset_n = 1'b1;

      run_edges(P1, 1'b1, "p1");

      foreach (vecs[i]) begin
         int e;
         e = divs[vecs[i].cfg] * (vecs[i].idx + 1) + vecs[i].kind;
         check(vecs[i].name,
               (vecs[i].kind == 0) ? hist_qs[vecs[i].cfg][e] : hist_q[vecs[i].cfg][e],
               vecs[i].expv);
      end

      mism = 0;
      for (int e = 4; e <= 400; e++) if (hist_qs[0][e] != hist_qs[0][e+256]) mism++;
      check("period_256", mism, 0);

      mism = 0;
      for (int e = 5; e <= 261; e++) if (hist_q[1][e] != hist_qs[1][e-1]) mism++;
      check("k0_delay1", mism, 0);

      mism = 0;
      for (int n = 0; n <= 150; n++) begin
         dev = hist_qs[2][4*(n+1)] - ref_lut(n % 64);
         if (dev < -512 || dev > 511) mism++;
      end
      check("noise_range", mism, 0);

      pmin_x = 0; pmax_x = 0; pmin_y = 0; pmax_y = 0;
      for (int n = 64; n < 160; n++) begin
         int dx, dy;
         dx = hist_qs[2][4*(n+1)] - hist_qs[0][4*(n+1)];
         dy = hist_q[2][4*(n+1)+1] - hist_q[0][4*(n+1)+1];
         if (n == 64 || dx < pmin_x) pmin_x = dx;
         if (n == 64 || dx > pmax_x) pmax_x = dx;
         if (n == 64 || dy < pmin_y) pmin_y = dy;
         if (n == 64 || dy > pmax_y) pmax_y = dy;
      end
      check("noise_pp_reduced", ((pmax_y - pmin_y) < (pmax_x - pmin_x)) ? 1 : 0, 1);

      mx_v = -100000; arg_n = 0;
      for (int n = 64; n < 128; n++) begin
         peak = hist_q[0][4*(n+1)+1];
         if (peak > mx_v) begin
            mx_v  = peak;
            arg_n = n;
         end
      end
      check("avg_amp_below_8192", (mx_v < 8192 && mx_v > 0) ? 1 : 0, 1);
      check("avg_phase_lag", (arg_n > 80 && arg_n < 96) ? 1 : 0, 1);

      mism = 0;
      for (int e = 1; e <= P1; e++) if (hist_q[3][e] > 8704 || hist_q[3][e] < -8704) mism++;
      check("stress_q_bounded", mism, 0);
      check("no_x_values", xcnt, 0);

      async_reset("r1");
      run_edges(int'($urandom_range(20, 200)), 1'b0, "p2");
      async_reset("r2");
      run_edges(60, 1'b0, "p3");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
